// File: rtl/sky130_as_sc_hs_rocnt.sv
// Gated ring-oscillator edge counter: counts synchronized RO_IN rises over a
// programmable window of CLK cycles, with saturation and overflow flag.
module sky130_as_sc_hs_rocnt #(
  parameter int unsigned CW = 24,
  parameter int unsigned WW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [WW-1:0] WIN,
  input  logic          RO_IN,
  output logic [CW-1:0] COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF,
  input  logic          VPWR,
  input  logic          VGND,
  input  logic          VPB,
  input  logic          VNB
);

  typedef enum logic [1:0] {StIdle, StMeas, StFin} state_e;

  localparam logic [CW-1:0] CntMax = '1;

  state_e        state_q, state_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          s1_q, s2_q, s3_q;
  logic          rise;
  logic          busy, done;

  // Supply pins carry no logic.
  logic unused_supply;
  assign unused_supply = ^{VPWR, VGND, VPB, VNB};

  // Synchronizer runs regardless of measurement state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= RO_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (START) begin
          win_cnt_d = WIN;
          count_d   = '0;
          ovf_d     = 1'b0;
          state_d   = (WIN == '0) ? StFin : StMeas;
        end
      end
      StMeas: begin
        if (rise) begin
          if (count_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        win_cnt_d = win_cnt_q - WW'(1);
        if (win_cnt_q == WW'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign BUSY  = busy;
  assign DONE  = done;

endmodule

// File: tb/tb_sky130_as_sc_hs_rocnt.sv
// Bench for sky130_as_sc_hs_rocnt: a wide and a 4-bit-count instance share stimulus;
// directed vectors, corner sequences and random traffic checked against a window model.
module tb_sky130_as_sc_hs_rocnt;

  localparam int unsigned WW = 16;
  localparam int unsigned Max24 = 32'h00FF_FFFF;
  localparam int unsigned Max4 = 15;

  logic          CLK = 1'b0;
  logic          RST, START, RO_IN;
  logic [WW-1:0] WIN;
  logic [23:0]   count24;
  logic [3:0]    count4;
  logic          busy24, done24, ovf24;
  logic          busy4, done4, ovf4;

  always #5 CLK = ~CLK;

  sky130_as_sc_hs_rocnt #(.CW(24), .WW(WW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .WIN(WIN), .RO_IN(RO_IN),
    .COUNT(count24), .BUSY(busy24), .DONE(done24), .OVF(ovf24),
    .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0)
  );

  sky130_as_sc_hs_rocnt #(.CW(4), .WW(WW)) dut4 (
    .CLK(CLK), .RST(RST), .START(START), .WIN(WIN), .RO_IN(RO_IN),
    .COUNT(count4), .BUSY(busy4), .DONE(done4), .OVF(ovf4),
    .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0)
  );

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int ro_mode = 0;

  // Window model: a measurement accepted at edge acc counts detected rises at edges
  // acc+1 .. acc+win; outputs after edge n are busy for acc <= n <= acc+win.
  int n_edge = 0;
  int acc = 0;
  int win_m = 0;
  int raw = 0;
  int free_at = 0;
  bit active = 1'b0;
  bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n_edge, act, exp);
    end
  endfunction

  task automatic model_edge();
    bit r;
    n_edge++;
    r = h1 & ~h2;
    if (RST) begin
      active  = 1'b0;
      raw     = 0;
      free_at = n_edge + 1;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      if (active && n_edge > acc && n_edge <= acc + win_m && r) raw++;
      if (START && n_edge >= free_at) begin
        acc     = n_edge;
        win_m   = int'(WIN);
        raw     = 0;
        active  = 1'b1;
        free_at = n_edge + int'(WIN) + 2;
      end
      h2 = h1; h1 = h0; h0 = RO_IN;
    end
  endtask

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  task automatic tick();
    bit eb, ed;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (chk_en) begin
      eb = active && n_edge >= acc && n_edge <= acc + win_m;
      ed = active && n_edge == acc + win_m;
      chk("sb_busy", 32'(busy24), 32'(eb));
      chk("sb_done", 32'(done24), 32'(ed));
      chk("sb_count", 32'(count24), 32'(sat(raw, Max24)));
      chk("sb_ovf", 32'(ovf24), 32'(raw > Max24));
      chk("sb_busy4", 32'(busy4), 32'(eb));
      chk("sb_done4", 32'(done4), 32'(ed));
      chk("sb_count4", 32'(count4), 32'(sat(raw, Max4)));
      chk("sb_ovf4", 32'(ovf4), 32'(raw > Max4));
    end
    case (ro_mode)
      0:       RO_IN = 1'b0;
      1:       RO_IN = ~RO_IN;
      default: RO_IN = 1'($urandom_range(0, 1));
    endcase
  endtask

  typedef struct {
    int unsigned win;
    int          tog;
    int unsigned exp_cnt;
    int unsigned exp_cnt4;
    bit          exp_ovf4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    int seen;
    vecs[0] = '{100, 0, 0, 0, 1'b0};
    vecs[1] = '{8, 1, 4, 4, 1'b0};
    vecs[2] = '{40, 1, 20, 15, 1'b1};
    vecs[3] = '{0, 1, 0, 0, 1'b0};
    vecs[4] = '{30, 1, 15, 15, 1'b0};
    vecs[5] = '{32, 1, 16, 15, 1'b1};
    vecs[6] = '{2, 1, 1, 1, 1'b0};

    RST = 1'b1; START = 1'b0; WIN = '0; RO_IN = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy", 32'(busy24), 0);
    chk("rst_count", 32'(count24), 0);
    chk("rst_ovf", 32'(ovf24), 0);

    // First cycle out of reset already accepts START.
    RST = 1'b0; START = 1'b1; WIN = 16'd2;
    tick();
    START = 1'b0;
    chk("first_start_busy", 32'(busy24), 1);
    repeat (6) tick();

    foreach (vecs[i]) begin
      ro_mode = vecs[i].tog;
      repeat (6) tick();
      WIN = 16'(vecs[i].win); START = 1'b1;
      tick();
      START = 1'b0; WIN = 16'hFFFF;
      k = 0;
      while (!done24 && k < int'(vecs[i].win) + 5) begin
        tick();
        k++;
      end
      chk($sformatf("v%0d_done_lat", i), 32'(k), vecs[i].win);
      chk($sformatf("v%0d_count", i), 32'(count24), vecs[i].exp_cnt);
      chk($sformatf("v%0d_ovf", i), 32'(ovf24), 0);
      chk($sformatf("v%0d_count4", i), 32'(count4), vecs[i].exp_cnt4);
      chk($sformatf("v%0d_ovf4", i), 32'(ovf4), 32'(vecs[i].exp_ovf4));
      tick();
      chk($sformatf("v%0d_idle", i), 32'(busy24), 0);
      chk($sformatf("v%0d_hold", i), 32'(count24), vecs[i].exp_cnt);
    end

    // Re-pulsed START mid-window with a different WIN is ignored.
    ro_mode = 1;
    WIN = 16'd20; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    WIN = 16'd3; START = 1'b1;
    tick();
    START = 1'b0;
    k = 6;
    while (!done24 && k < 30) begin
      tick();
      k++;
    end
    chk("restart_ignored_lat", 32'(k), 20);
    chk("restart_ignored_cnt", 32'(count24), 10);
    repeat (3) tick();

    // START held high: new measurement right after the idle cycle following FIN.
    WIN = 16'd3; START = 1'b1;
    tick();
    k = 0;
    while (!done24 && k < 10) begin
      tick();
      k++;
    end
    chk("b2b_done_lat", 32'(k), 3);
    tick();
    chk("b2b_idle", 32'(busy24), 0);
    tick();
    chk("b2b_restart", 32'(busy24), 1);
    START = 1'b0;
    repeat (6) tick();

    // Reset aborts a running window with no DONE.
    WIN = 16'd20; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", 32'(busy24), 0);
    chk("abort_count", 32'(count24), 0);
    chk("abort_ovf", 32'(ovf24), 0);
    seen = 0;
    repeat (25) begin
      tick();
      if (done24 || done4) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);

    ro_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      RST   = ($urandom_range(0, 299) == 0);
      START = ($urandom_range(0, 3) == 0);
      WIN   = 16'($urandom_range(0, 40));
      tick();
    end
    RST = 1'b0; START = 1'b0;
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sky130_as_sc_hs_rocnt.md
SKY130_AS_SC_HS_ROCNT -- requirements
Module: sky130_as_sc_hs_rocnt

Interface
REQ-001 SHALL have parameter CW, default 24, COUNT width in bits (CW >= 4).
REQ-002 SHALL have parameter WW, default 16, gate-window width in bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port START  input  1  measurement request, sampled only in IDLE.
REQ-006 SHALL have port WIN  input  WW  gate window length in CLK cycles, latched when START is accepted.
REQ-007 SHALL have port RO_IN  input  1  asynchronous ring-oscillator tap (pre-divided so that RO_IN frequency <= CLK/2).
REQ-008 SHALL have port COUNT  output  CW  rising-edge count of the last completed window.
REQ-009 SHALL have port BUSY  output  1  high while a measurement is in progress.
REQ-010 SHALL have port DONE  output  1  single-cycle completion pulse.
REQ-011 SHALL have port OVF  output  1  count saturated during the last window.
REQ-012 SHALL have ports VPWR, VGND, VPB, VNB  input  1 each  supply/bias pins with no functional effect.

Function
REQ-013 SHALL pass RO_IN through a 2-flop synchronizer (s1, s2) followed by a delay flop s3; detected rise = s2 & ~s3.
REQ-014 SHALL operate synchronizer flops continuously, independent of FSM state.
REQ-015 SHALL implement FSM states IDLE, MEAS, FIN.
REQ-016 IDLE: START=1 in cycle t -> latch WIN, clear COUNT and OVF, enter MEAS (or FIN if WIN=0) at t+1.
REQ-017 MEAS: SHALL last exactly WIN cycles (t+1 .. t+WIN), using a WW-bit down-counter loaded with WIN.
REQ-018 MEAS: each cycle with detected rise = 1 SHALL increment COUNT by 1; rises outside MEAS SHALL be ignored.
REQ-019 COUNT SHALL saturate at 2^CW-1; an increment attempt at saturation SHALL set OVF, which stays set until the next accepted START or RST.
REQ-020 FIN: SHALL last one cycle (t+WIN+1, or t+1 when WIN=0) with DONE=1, then return to IDLE.
REQ-021 BUSY SHALL be 1 in MEAS and FIN, 0 in IDLE.
REQ-022 COUNT and OVF SHALL be stable and valid from the FIN cycle until the next accepted START.
REQ-023 START while BUSY=1 SHALL be ignored (no restart, no latch of WIN).
REQ-024 START held high SHALL start a new measurement in the IDLE cycle following FIN (back-to-back).
REQ-025 WIN changes after acceptance SHALL have no effect on the measurement in progress.
REQ-026 RO_IN-to-count latency: a RO_IN rise sampled by s1 at edge k SHALL appear as detected rise in cycle k+2 (counted if that cycle is in MEAS).

Reset
REQ-027 RST=1 at a CLK edge SHALL force: FSM=IDLE, COUNT=0, OVF=0, BUSY=0, DONE=0, window counter=0, s1=s2=s3=0.
REQ-028 RST SHALL take priority over START and over any in-progress MEAS/FIN; no DONE pulse for an aborted measurement.
REQ-029 First START accepted SHALL be in the first cycle with RST=0.

Verification
REQ-030 RO_IN=0 constant, WIN=100, START pulse -> DONE at t+101, COUNT=0, OVF=0, BUSY high t+1..t+101.
REQ-031 RO_IN toggling every CLK cycle (running >=4 cycles before START), WIN=8 -> COUNT=4 at DONE, OVF=0.
REQ-032 CW=4, RO_IN toggling every cycle, WIN=40 -> COUNT=15, OVF=1 at DONE.
REQ-033 WIN=0, START -> BUSY=1 and DONE=1 at t+1 only, COUNT=0, IDLE at t+2.
REQ-034 START re-pulsed mid-MEAS with different WIN -> ignored; DONE timing and COUNT match original WIN.
REQ-035 RST asserted at t+5 of WIN=20 measurement -> at t+6 BUSY=0, COUNT=0, OVF=0; no DONE through t+30.
